// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit / request-to-send, 8 data bits,
// odd parity and stop, then device acknowledge check. Pins driven via open-drain enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned START_HOLD     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAITIDLE, S_DONE
    } state_t;

    // Synchronizers reset to the idle (released, high) bus level.
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Run-length filter: a new clock level is accepted only after FILTER_LEN equal samples.
    logic          filt_q, filt_d, fall_q;
    logic [FW-1:0] fcnt_q, fcnt_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                               fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d, nack_q, nack_d;
    logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        enack_q, enack_d, etmo_q, etmo_d;
    logic        tmo;

    assign tmo = (cnt_q >= 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_d     = par_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        enack_d   = 1'b0;
        etmo_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_valid && !busy_q) begin
                    state_d   = S_INHIBIT;
                    data_d    = tx_data;
                    par_d     = ~^tx_data;
                    cnt_d     = '0;
                    bit_d     = '0;
                    nack_d    = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_REQ: begin
                if (cnt_q == 32'(START_HOLD - 1)) begin
                    state_d  = S_SEND;
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SEND: begin
                cnt_d = cnt_q + 32'd1;
                if (fall_q) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8)       data_oe_d = ~data_q[bit_q[2:0]];
                    else if (bit_q == 4'd8) data_oe_d = ~par_q;
                    else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + 32'd1;
                if (fall_q) begin
                    nack_d  = dat_s2_q;
                    state_d = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                cnt_d = cnt_q + 32'd1;
                if (filt_q && dat_s2_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    enack_d = nack_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout overrides everything else in the bus phase, including a pending nack.
        if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAITIDLE) && tmo) begin
            state_d   = S_DONE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            enack_d   = 1'b0;
            etmo_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            enack_q   <= 1'b0;
            etmo_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_q     <= par_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            enack_q   <= enack_d;
            etmo_q    <= etmo_d;
        end
    end

    assign tx_ready    = ~busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_nack    = enack_q;
    assign err_timeout = etmo_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device model that clocks frames,
// captures the bits it reads and answers with ack, nack or silence.
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int SH   = 20;
    localparam int TMO  = 4000;
    localparam int FL   = 8;
    localparam int HALF = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
    logic       tx_ready, ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
    logic       busy, done, err_nack, err_timeout;

    int checks = 0, errors = 0, done_cnt = 0, stray = 0;

    // Wired-AND open-drain bus: either side can pull a line low.
    assign ps2_clk_i  = ~ps2_clk_oe & ~dev_clk_low & ~glitch;
    assign ps2_data_i = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .START_HOLD(SH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err_nack(err_nack),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        else if (err_nack || err_timeout) stray++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode: 0 = device acks, 1 = device nacks, 2 = device never clocks
    task automatic xfer(input logic [7:0] d, input int mode, input bit glitch_en, input bit spam);
        logic [9:0] cap, exp;
        int n, d0;
        cap = '0;
        d0 = done_cnt;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("accept_busy", 32'(busy), 1);
        chk("accept_clk_oe", 32'(ps2_clk_oe), 1);
        n = 1;
        while (!ps2_data_oe && n < 4 * INH) begin @(negedge clk); n++; end
        chk("inhibit_len", n - 1, INH);
        n = 0;
        while (ps2_clk_oe && n < 4 * SH) begin @(negedge clk); n++; end
        chk("start_hold", n, SH);
        chk("start_bit", 32'(ps2_data_oe), 1);
        if (spam) begin
            tx_data  = 8'hFF;
            tx_valid = 1'b1;
            cyc(8);
            tx_valid = 1'b0;
        end
        if (mode == 2) begin
            n = 0;
            while (!done && n < TMO + 50) begin @(negedge clk); n++; end
            chk("timeout_len", 32'(n >= TMO - 2 && n <= TMO + 2), 1);
            chk("tmo_done", 32'(done), 1);
            chk("tmo_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
            chk("tmo_flag", 32'(err_timeout), 1);
            chk("tmo_nack", 32'(err_nack), 0);
        end else begin
            cyc(30);
            for (int i = 0; i < 10; i++) begin
                dev_clk_low = 1'b1;
                cyc(HALF);
                cap[i] = ps2_data_i;
                dev_clk_low = 1'b0;
                if (glitch_en && i == 3) begin
                    cyc(20);
                    glitch = 1'b1;
                    cyc(3);
                    glitch = 1'b0;
                    cyc(HALF - 23);
                end else begin
                    cyc(HALF);
                end
            end
            if (mode == 0) dev_data_low = 1'b1;
            cyc(10);
            dev_clk_low = 1'b1;
            cyc(HALF);
            dev_clk_low = 1'b0;
            cyc(10);
            dev_data_low = 1'b0;
            n = 0;
            while (!done && n < 400) begin @(negedge clk); n++; end
            chk("done_seen", 32'(done), 1);
            chk("nack_flag", 32'(err_nack), (mode == 1) ? 1 : 0);
            chk("tmo_flag_clear", 32'(err_timeout), 0);
            // Device-side view of the frame: data LSB first, odd parity, stop high.
            exp = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
            chk("frame", 32'(cap), 32'(exp));
        end
        cyc(5);
        chk("done_once", done_cnt - d0, 1);
        chk("idle_after", 32'(busy), 0);
        chk("ready_after", 32'(tx_ready), 1);
    endtask

    initial begin
        int n;
        cyc(3);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_flags", {29'd0, busy, done, err_nack | err_timeout}, 0);
        rst = 1'b1;
        cyc(2);

        xfer(8'hED, 0, 1'b0, 1'b0);
        xfer(8'h01, 0, 1'b0, 1'b0);
        xfer(8'h00, 0, 1'b0, 1'b0);
        xfer(8'hA5, 1, 1'b0, 1'b0);
        xfer(8'($urandom), 0, 1'b1, 1'b1);
        xfer(8'h3C, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) xfer(8'($urandom), 0, 1'b0, 1'b0);
        xfer(8'h5A, 2, 1'b0, 1'b0);

        // Reset mid-SEND with the host pulling data low must release the bus at once.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && n < 2 * (INH + SH)) begin @(negedge clk); n++; end
        cyc(30);
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            cyc(HALF);
            dev_clk_low = 1'b0;
            cyc(HALF);
        end
        chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_async_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(tx_ready), 1);
        chk("post_reset_flags", {29'd0, busy, done, err_nack | err_timeout}, 0);

        xfer(8'($urandom), 0, 1'b0, 1'b0);
        chk("stray_flags", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
